// File: rtl/gups_rr_arb.sv
// N-to-1 memory port arbiter with one outstanding transaction (IDLE -> BUSY -> RESP).
// Round-robin with bounded bursts (mode=0) or lowest-index-wins priority (mode=1).
module gups_rr_arb #(
  parameter int N     = 4,
  parameter int AW    = 64,
  parameter int DW    = 64,
  parameter int BURST = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic [N*AW-1:0] addr_a,
  input  logic [N*DW-1:0] dout_a,
  output logic [N*DW-1:0] din_a,
  input  logic [N-1:0]    req_a,
  input  logic [N-1:0]    wr_a,
  output logic [N-1:0]    rdy_a,
  output logic [AW-1:0]   addr,
  output logic [DW-1:0]   dout,
  input  logic [DW-1:0]   din,
  output logic            req,
  output logic            wr,
  input  logic            rdy,
  output logic [N-1:0]    gnt
);

  localparam int IW = $clog2(N);
  localparam logic [3:0]    BURST_C  = 4'(BURST);
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] lastWin_q, lastWin_d;
  logic [3:0]    burstCnt_q, burstCnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  rdyA_q, rdyA_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          req_q, req_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] dinArr_q [N];
  logic [DW-1:0] dinArr_d [N];

  logic [AW-1:0] addrArr [N];
  logic [DW-1:0] doutArr [N];
  logic [IW-1:0] winIdx;
  logic [IW-1:0] cand;
  logic [3:0]    winCnt;
  logic [N-1:0]  others;

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign addrArr[gi]             = addr_a[gi*AW +: AW];
    assign doutArr[gi]             = dout_a[gi*DW +: DW];
    assign din_a[gi*DW +: DW]      = dinArr_q[gi];
  end

  // Winner selection; a zero burst count means no valid last winner, so the scan starts after N-1.
  always_comb begin
    winIdx = lastWin_q;
    winCnt = 4'd1;
    cand   = '0;
    others = req_a;
    others[lastWin_q] = 1'b0;
    if (mode) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req_a[IW'(i)]) winIdx = IW'(i);
      end
    end else if (req_a[lastWin_q] && (burstCnt_q != 4'd0) &&
                 ((burstCnt_q < BURST_C) || (others == '0))) begin
      winIdx = lastWin_q;
      winCnt = (burstCnt_q < BURST_C) ? burstCnt_q + 4'd1 : BURST_C;
    end else begin
      for (int k = N; k >= 1; k--) begin
        cand = IW'((int'(lastWin_q) + k) % N);
        if (req_a[cand]) winIdx = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lastWin_d  = lastWin_q;
    burstCnt_d = burstCnt_q;
    gnt_d      = gnt_q;
    rdyA_d     = '0;
    addr_d     = addr_q;
    dout_d     = dout_q;
    req_d      = req_q;
    wr_d       = wr_q;
    dinArr_d   = dinArr_q;
    unique case (state_q)
      IDLE: begin
        if (|req_a) begin
          state_d        = BUSY;
          lastWin_d      = winIdx;
          burstCnt_d     = winCnt;
          gnt_d          = '0;
          gnt_d[winIdx]  = 1'b1;
          addr_d         = addrArr[winIdx];
          dout_d         = doutArr[winIdx];
          wr_d           = wr_a[winIdx];
          req_d          = 1'b1;
        end
      end
      BUSY: begin
        if (rdy) begin
          state_d           = RESP;
          req_d             = 1'b0;
          rdyA_d[lastWin_q] = 1'b1;
          if (!wr_q) dinArr_d[lastWin_q] = din;
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      lastWin_q  <= LAST_RST;
      burstCnt_q <= '0;
      gnt_q      <= '0;
      rdyA_q     <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      req_q      <= 1'b0;
      wr_q       <= 1'b0;
      for (int i = 0; i < N; i++) dinArr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      lastWin_q  <= lastWin_d;
      burstCnt_q <= burstCnt_d;
      gnt_q      <= gnt_d;
      rdyA_q     <= rdyA_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      req_q      <= req_d;
      wr_q       <= wr_d;
      dinArr_q   <= dinArr_d;
    end
  end

  assign rdy_a = rdyA_q;
  assign gnt   = gnt_q;
  assign addr  = addr_q;
  assign dout  = dout_q;
  assign req   = req_q;
  assign wr    = wr_q;

endmodule

// File: tb/tb_gups_rr_arb.sv
// Scoreboard bench for gups_rr_arb: instance A runs strict round-robin (BURST=1),
// instance B runs BURST=3; both see the same client and memory-side stimulus.
module tb_gups_rr_arb;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            mode = 1'b0;
  logic            rdy = 1'b0;
  logic [DW-1:0]   din = '0;
  logic [N*AW-1:0] addr_a = '0;
  logic [N*DW-1:0] dout_a = '0;
  logic [N-1:0]    req_a = '0;
  logic [N-1:0]    wr_a = '0;

  logic [N*DW-1:0] cliDinA, cliDinB;
  logic [N-1:0]    cliRdyA, cliRdyB, gntA, gntB;
  logic [AW-1:0]   memAddrA, memAddrB;
  logic [DW-1:0]   memDoutA, memDoutB;
  logic            memReqA, memReqB, memWrA, memWrB;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] dout;
    int            gap;
  } expT;

  expT           qA[$];
  expT           qB[$];
  expT           eA, eB;
  logic [AW-1:0] addrVal [N];
  logic [DW-1:0] doutVal [N];
  logic [DW-1:0] expDin  [N];
  int            vectorCount = 0;
  int            missCount = 0;
  int            cycle = 0;
  int            lastGrantA = 0;
  int            lastGrantB = 0;
  logic [N-1:0]  prevGntA = '0;
  logic [N-1:0]  prevGntB = '0;

  gups_rr_arb #(.N(N), .AW(AW), .DW(DW), .BURST(1)) dutA (
    .clk(clk), .reset(reset), .mode(mode),
    .addr_a(addr_a), .dout_a(dout_a), .din_a(cliDinA),
    .req_a(req_a), .wr_a(wr_a), .rdy_a(cliRdyA),
    .addr(memAddrA), .dout(memDoutA), .din(din),
    .req(memReqA), .wr(memWrA), .rdy(rdy), .gnt(gntA)
  );

  gups_rr_arb #(.N(N), .AW(AW), .DW(DW), .BURST(3)) dutB (
    .clk(clk), .reset(reset), .mode(mode),
    .addr_a(addr_a), .dout_a(dout_a), .din_a(cliDinB),
    .req_a(req_a), .wr_a(wr_a), .rdy_a(cliRdyB),
    .addr(memAddrB), .dout(memDoutB), .din(din),
    .req(memReqB), .wr(memWrB), .rdy(rdy), .gnt(gntB)
  );

  // Free-running clock plus a cycle counter used to measure grant spacing.
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [255:0] actual,
                             input logic [255:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [N-1:0] oneHot(input int ch);
    logic [N-1:0] m = 1;
    return m << ch;
  endfunction

  task automatic applyStimulus(input logic [N-1:0] reqMask, input logic [N-1:0] wrMask);
    for (int i = 0; i < N; i++) begin
      addr_a[i*AW +: AW] = addrVal[i];
      dout_a[i*DW +: DW] = doutVal[i];
    end
    wr_a  = wrMask;
    req_a = reqMask;
  endtask

  task automatic expectGrant(input bit forB, input int ch, input int gap);
    expT e;
    e.gnt  = oneHot(ch);
    e.addr = addrVal[ch];
    e.wr   = wr_a[ch];
    e.dout = doutVal[ch];
    e.gap  = gap;
    if (forB) qB.push_back(e);
    else      qA.push_back(e);
  endtask

  task automatic waitQueue(input bit forB, input int bound);
    int n = 0;
    while (((forB ? qB.size() : qA.size()) != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput(forB ? "drainB" : "drainA", forB ? qB.size() : qA.size(), 0);
  endtask

  // Waits for the completion pulse on A, checks every read-data slice, drops the request.
  task automatic waitResponse(input int ch, input int bound);
    int n = 0;
    while (cliRdyA == '0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rdyA", cliRdyA, oneHot(ch));
    checkOutput("reqLowInResp", memReqA, 0);
    for (int i = 0; i < N; i++) checkOutput("dinSlice", cliDinA[i*DW +: DW], expDin[i]);
    req_a = '0;
    @(negedge clk);
    checkOutput("rdyPulseWidth", cliRdyA, '0);
  endtask

  task automatic resetDut();
    reset = 1'b0;
    req_a = '0;
    mode  = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) expDin[i] = '0;
    reset = 1'b1;
  endtask

  // Monitor for A: every fresh grant is popped against the scoreboard, including spacing.
  always @(negedge clk) begin
    if (gntA != '0 && prevGntA == '0) begin
      if (qA.size() > 0) begin
        eA = qA.pop_front();
        checkOutput("gntA", gntA, eA.gnt);
        checkOutput("addrA", memAddrA, eA.addr);
        checkOutput("wrA", memWrA, eA.wr);
        checkOutput("doutA", memDoutA, eA.dout);
        checkOutput("reqA", memReqA, 1);
        if (eA.gap != 0) checkOutput("gapA", cycle - lastGrantA, eA.gap);
      end
      lastGrantA = cycle;
    end
    prevGntA = gntA;
  end

  // Monitor for B: same scoreboard discipline for the burst instance.
  always @(negedge clk) begin
    if (gntB != '0 && prevGntB == '0) begin
      if (qB.size() > 0) begin
        eB = qB.pop_front();
        checkOutput("gntB", gntB, eB.gnt);
        checkOutput("addrB", memAddrB, eB.addr);
        if (eB.gap != 0) checkOutput("gapB", cycle - lastGrantB, eB.gap);
      end
      lastGrantB = cycle;
    end
    prevGntB = gntB;
  end

  // Main sequence: reset, read, write, fairness, burst, priority, reset mid-transaction.
  initial begin
    int burstSeq [7] = '{0, 0, 0, 1, 1, 1, 0};
    int rrSeq [5] = '{0, 1, 2, 3, 0};
    addrVal = '{64'h40, 64'h100, 64'h200, 64'h300};
    doutVal = '{64'h11, 64'h22, 64'h33, 64'h55};
    for (int i = 0; i < N; i++) expDin[i] = '0;
    applyStimulus('0, '0);

    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstReq", memReqA, 0);
    checkOutput("rstWr", memWrA, 0);
    checkOutput("rstAddr", memAddrA, 0);
    checkOutput("rstDout", memDoutA, 0);
    checkOutput("rstRdyA", cliRdyA, 0);
    checkOutput("rstGnt", gntA, 0);
    checkOutput("rstDinA", cliDinA, 0);
    checkOutput("rstGntB", gntB, 0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] single read on channel 1");
    expectGrant(0, 1, 0);
    applyStimulus(4'b0010, 4'b0000);
    @(negedge clk);
    checkOutput("readReq", memReqA, 1);
    checkOutput("readAddr", memAddrA, 64'h100);
    checkOutput("readWr", memWrA, 0);
    @(negedge clk);
    checkOutput("busyHoldReq", memReqA, 1);
    checkOutput("busyHoldGnt", gntA, 4'b0010);
    rdy = 1'b1;
    din = 64'hDEADBEEF;
    expDin[1] = 64'hDEADBEEF;
    waitResponse(1, 8);
    checkOutput("idleGnt", gntA, 0);

    $display("[TB] write on channel 3");
    din = 64'hBAD0BAD0;
    applyStimulus(4'b1000, 4'b1001);
    expectGrant(0, 3, 0);
    waitResponse(3, 8);
    applyStimulus('0, '0);
    rdy = 1'b0;

    $display("[TB] round-robin fairness");
    resetDut();
    rdy = 1'b1;
    foreach (rrSeq[i]) expectGrant(0, rrSeq[i], (i == 0) ? 0 : 3);
    applyStimulus(4'b1111, 4'b0000);
    waitQueue(0, 40);
    req_a = '0;
    repeat (4) @(negedge clk);

    $display("[TB] burst of three");
    resetDut();
    foreach (burstSeq[i]) expectGrant(1, burstSeq[i], (i == 0) ? 0 : 3);
    applyStimulus(4'b0011, 4'b0000);
    waitQueue(1, 60);
    req_a = 4'b0001;
    repeat (4) expectGrant(1, 0, 3);
    waitQueue(1, 40);
    req_a = '0;
    repeat (4) @(negedge clk);

    $display("[TB] fixed priority");
    resetDut();
    mode = 1'b1;
    for (int i = 0; i < 3; i++) expectGrant(0, 2, (i == 0) ? 0 : 3);
    applyStimulus(4'b1100, 4'b0000);
    waitQueue(0, 40);
    req_a = 4'b1110;
    repeat (2) expectGrant(0, 1, 3);
    waitQueue(0, 30);
    req_a = '0;
    mode = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] reset in the middle of a transaction");
    resetDut();
    rdy = 1'b1;
    din = 64'hCAFE;
    expDin[0] = 64'hCAFE;
    expectGrant(0, 0, 0);
    applyStimulus(4'b0001, 4'b0000);
    waitResponse(0, 8);
    rdy = 1'b0;
    expectGrant(0, 1, 0);
    applyStimulus(4'b1111, 4'b0000);
    waitQueue(0, 10);
    checkOutput("midBusyReq", memReqA, 1);
    rdy = 1'b1;
    din = 64'hF00D;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abortReq", memReqA, 0);
    checkOutput("abortRdyA", cliRdyA, 0);
    checkOutput("abortDinA", cliDinA, 0);
    checkOutput("abortGnt", gntA, 0);
    @(negedge clk);
    checkOutput("abortRdyA2", cliRdyA, 0);
    for (int i = 0; i < N; i++) expDin[i] = '0;
    expectGrant(0, 0, 0);
    reset = 1'b1;
    waitQueue(0, 10);
    req_a = '0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/gups_rr_arb.md
GUPS_RR_ARB -- requirements
Module: gups_rr_arb

Interface
REQ-001 SHALL have parameter N, default 4, meaning the number of client channels; legal range 2..16.
REQ-002 SHALL have parameter AW, default 64, meaning the address width.
REQ-003 SHALL have parameter DW, default 64, meaning the data width.
REQ-004 SHALL have parameter BURST, default 1, meaning the maximum number of consecutive grants to one channel while others wait; legal range 1..15.
REQ-005 SHALL have ports: clk  in  1  the single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have port mode  in  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-008 SHALL have port addr_a  in  N*AW  client addresses; channel i occupies [i*AW +: AW].
REQ-009 SHALL have port dout_a  in  N*DW  client write data, sliced like addr_a.
REQ-010 SHALL have port din_a  out  N*DW  read data returned to clients, sliced like addr_a.
REQ-011 SHALL have port req_a  in  N  client request, one bit per channel.
REQ-012 SHALL have port wr_a  in  N  client write strobe (1 = write, 0 = read).
REQ-013 SHALL have port rdy_a  out  N  one-cycle completion pulse per channel.
REQ-014 SHALL have port addr  out  AW  memory-side address.
REQ-015 SHALL have port dout  out  DW  memory-side write data.
REQ-016 SHALL have port din  in  DW  memory-side read data.
REQ-017 SHALL have port req  out  1  memory-side request.
REQ-018 SHALL have port wr  out  1  memory-side write strobe.
REQ-019 SHALL have port rdy  in  1  memory-side completion.
REQ-020 SHALL have port gnt  out  N  one-hot current owner; all-zero when IDLE.

Function
REQ-021 SHALL implement states IDLE, BUSY and RESP.
- IDLE -> BUSY when any req_a bit is 1.
- BUSY -> RESP on rdy=1.
- RESP -> IDLE unconditionally.
REQ-022 In IDLE with any request, SHALL select a winner g and set gnt to one-hot(g).
- Same edge: register addr, dout and wr from slice g.
- Same edge: set req=1.
- Request-to-memory latency is therefore 1 cycle.
REQ-023 In BUSY, SHALL hold addr, dout, wr, req and gnt stable until and including the cycle rdy=1 is sampled.
REQ-024 On the edge where rdy=1 is sampled in BUSY, SHALL perform all of the following:
- clear req;
- latch din into din_a slice g (only on reads, i.e. wr=0);
- set rdy_a[g]=1 for exactly the RESP cycle.
REQ-025 SHALL leave din_a slices of non-winning channels, and slice g on writes, unchanged.
REQ-026 SHALL ignore rdy while in IDLE or RESP.
REQ-027 SHALL ignore req_a during RESP, so a client that has not yet dropped its request is not re-granted stale.
REQ-028 Minimum transaction period SHALL be 3 cycles (IDLE, BUSY with rdy=1, RESP).
REQ-029 In round-robin mode (mode=0), SHALL apply a burst counter as follows:
- If the last winner L still requests and burst_cnt < BURST, re-grant L and increment burst_cnt.
- Otherwise, grant the first requesting channel scanning L+1, L+2, ..., wrapping modulo N, and set burst_cnt=1.
REQ-030 With BURST=1, mode 0 SHALL be strict round-robin, so each of N always-requesting channels is served once per N grants.
REQ-031 A burst re-grant SHALL be preempted when no other channel is requesting: the sole requester is re-granted regardless of burst_cnt, and burst_cnt saturates at BURST.
REQ-032 In fixed-priority mode (mode=1), SHALL grant the lowest-index requester, and burst_cnt SHALL be ignored.
REQ-033 A mode change SHALL take effect at the next IDLE arbitration and SHALL never disturb a transaction in progress.
REQ-034 Channel indices and the last-winner pointer SHALL be $clog2(N) bits, with wrap from N-1 to 0.
REQ-035 wr_a and dout_a of non-granted channels SHALL have no effect.

Reset
REQ-036 While reset=0 at a rising edge, SHALL force the following on that edge:
- state = IDLE;
- req=0, wr=0, addr=0, dout=0;
- rdy_a=0, gnt=0, din_a=0;
- last-winner pointer = N-1, so channel 0 wins the first round-robin scan;
- burst_cnt = 0.
REQ-037 Reset during BUSY or RESP SHALL abandon the transaction with no rdy_a pulse, and a rdy arriving in the reset cycle SHALL be ignored.

Verification
REQ-038 Single read: N=4, req_a=0010, addr_a[1]=0x100, rdy asserted 2 cycles after req.
- Response: req rises 1 cycle after req_a, addr=0x100, wr=0.
- Response: rdy_a=0010 for one cycle, din_a slice 1 = din value 0xDEADBEEF.
REQ-039 Round-robin fairness: BURST=1, mode=0, req_a=1111 held, rdy always 1.
- Response: gnt sequence 0001, 0010, 0100, 1000, 0001, with one grant every 3 cycles.
REQ-040 Burst: BURST=3, req_a=0011 held.
- Response: grants 0,0,0,1,1,1,0.
- Then drop req_a[1]: channel 0 is re-granted continuously.
REQ-041 Fixed priority: mode=1, req_a=1100 then 1110.
- Response: channel 2 is always granted; channel 3 starves.
- Then channel 1 wins once it requests.
REQ-042 Write: wr_a[3]=1, dout_a[3]=0x55.
- Response: wr=1, dout=0x55, rdy_a=1000, din_a unchanged.
REQ-043 Reset mid-BUSY: reset=0 while req=1 and rdy=1 in the same cycle.
- Response: next cycle req=0, rdy_a=0, din_a=0.
- Response: first grant after release goes to channel 0 when req_a=1111.
